bus_arbiter2: RTL and testbench
===============================

# bus_arbiter2

Two-master round-robin arbiter for the 32-bit memory/peripheral bus. It lets the CPU (master 0) and a second bus master (master 1, e.g. a DMA/blitter engine) share the single bus that fans out to the BRAM, PSRAM and text-area peripherals. It serialises transactions, one at a time, into a strobe/ready slave handshake. Each master receives the read data and a one-cycle acknowledge.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255, maximum WAIT cycles before a forced completion (only used with BUS_ARB_TIMEOUT_EN); range 1..65535.

Ports:
- clk_100mhz  in  1  system clock; all logic on the rising edge.
- rstn_i  in  1  reset; asynchronous, active-low.
- m0_req  in  1  master 0 request, level.
- m0_we  in  1  master 0 write enable (1 = write).
- m0_addr  in  32  master 0 address.
- m0_wdata  in  32  master 0 write data.
- m0_rdata  out  32  master 0 read data; valid while m0_ack=1, held afterwards.
- m0_ack  out  1  master 0 completion pulse.
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack: same as master 0, for master 1.
- s_stb  out  1  slave bus strobe, one cycle per transaction.
- s_we  out  1  slave write enable.
- s_addr  out  32  slave address.
- s_wdata  out  32  slave write data.
- s_rdata  in  32  slave read data, valid with s_ready.
- s_ready  in  1  slave completion.
- o_grant  out  2  one-hot owner of the current transaction; 2'b00 when idle.
- o_timeout  out  1  one-cycle pulse on a forced completion.

## Operation
- FSM: IDLE -> STB -> WAIT -> DONE -> IDLE.
- **IDLE:** requests are sampled here only.
  - One requester: grant it.
  - Both requesting: grant the master not served last (round-robin `last` flag). After reset, `last`=1, so master 0 wins the first tie.
  - On grant, latch we/addr/wdata into s_we/s_addr/s_wdata, set o_grant, update `last`, and go to STB.
- **STB:** s_stb=1 for exactly one cycle, then WAIT.
- **WAIT:** s_stb=0.
  - On s_ready=1, capture s_rdata into the granted mX_rdata, go to DONE.
  - s_ready is ignored in every other state.
- **DONE:** granted mX_ack=1 for one cycle. Then clear o_grant and go to IDLE.
- s_we/s_addr/s_wdata hold their latched values from grant until the next grant.
- Write transactions also capture s_rdata into mX_rdata; masters ignore it.
- Master contract:
  - Hold req and the request fields stable until ack.
  - Deassert req on the edge following ack, unless issuing a back-to-back request.
  - Deasserting req mid-transaction does not cancel it; the transaction completes and ack still pulses.
- mX_rdata of the non-granted master is never modified.
- Reset (any state, including mid-transaction): state=IDLE, `last`=1, timeout counter=0. The slave transaction is abandoned with no ack.

## Timing
- Reset values: s_stb=0, s_we=0, s_addr=0, s_wdata=0, m0_rdata=m1_rdata=0, m0_ack=m1_ack=0, o_grant=0, o_timeout=0.
- Cycle numbering, req seen in IDLE at cycle 0:
  - s_stb=1 in cycle 1.
  - WAIT begins in cycle 2.
  - s_ready in cycle k (k>=2) gives ack in cycle k+1.
- Minimum latency from req to ack is 3 cycles; minimum transaction period is 4 cycles.
- Back-to-back: a req still high in the IDLE cycle after DONE is a new request, subject to round-robin.
- Sustained dual requests therefore alternate 0,1,0,1…

## Configuration
- BUS_ARB_TIMEOUT_EN defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entering WAIT and increments each WAIT cycle without s_ready.
  - When it reaches TIMEOUT_CYCLES, go to DONE: mX_rdata=32'hFFFF_FFFF, o_timeout=1 in the DONE cycle, ack pulses normally.
  - s_ready in the same cycle as the limit wins: normal data, no timeout.
- BUS_ARB_TIMEOUT_EN undefined: no counter; WAIT lasts until s_ready, indefinitely; o_timeout is tied to 0.

## Test plan
- Master 0 read of 0x0000_1234, slave s_ready in the 2nd WAIT cycle with s_rdata=0x55 -> s_stb one cycle with s_addr=0x0000_1234, s_we=0; m0_rdata=0x0000_0055 and m0_ack for one cycle, 4 cycles after req; m1 outputs unchanged.
- Master 1 write 0x4000_0010 <- 0x0000_BEEF -> s_we=1, s_addr=0x4000_0010, s_wdata=0x0000_BEEF during s_stb; m1_ack pulse; o_grant=2'b10 from STB through DONE.
- Both masters request continuously from reset exit, slave ready immediately -> grant order 0,1,0,1; each transaction 4 cycles; never two acks in one cycle.
- With the macro and TIMEOUT_CYCLES=16, s_ready held 0 -> DONE after 16 WAIT cycles, m0_rdata=0xFFFF_FFFF, o_timeout and m0_ack pulse together. Without the macro -> still in WAIT after 1000 cycles, o_timeout=0.
- rstn_i pulsed low during WAIT of an m1 transaction -> all outputs 0 asynchronously, no m1_ack. After release, simultaneous requests -> master 0 granted first.
- m0_req dropped during WAIT -> transaction completes, m0_ack still pulses, no further s_stb.

Source files
------------

// File: rtl/bus_arbiter2_if.sv
// rtl/bus_arbiter2_if.sv - two-master request/ack bus plus the strobe/ready slave bus.
// The arbiter uses modport arb; requesters use master, the bus slave uses slave.
interface bus_arbiter2_if;
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [31:0] m0_rdata;
  logic        m0_ack;

  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [31:0] m1_rdata;
  logic        m1_ack;

  logic        s_stb;
  logic        s_we;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [31:0] s_rdata;
  logic        s_ready;

  modport arb (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_rdata, m0_ack,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_rdata, m1_ack,
    output s_stb, s_we, s_addr, s_wdata,
    input  s_rdata, s_ready
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_rdata, m0_ack,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_rdata, m1_ack
  );

  modport slave (
    input  s_stb, s_we, s_addr, s_wdata,
    output s_rdata, s_ready
  );
endinterface

// File: rtl/bus_arbiter2.sv
// rtl/bus_arbiter2.sv - two-master round-robin arbiter onto a strobe/ready slave bus.
// Optional WAIT timeout with forced completion is enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter2 #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk_100mhz,
  input  logic             rstn_i,
  bus_arbiter2_if.arb      bus,
  output logic [1:0]       o_grant,
  output logic             o_timeout
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] STB  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout_cycles
    $error("bus_arbiter2: TIMEOUT_CYCLES out of range 1..65535");
  end

  logic [1:0]  state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_q, last_d;
  logic        s_we_q, s_we_d;
  logic [31:0] s_addr_q, s_addr_d;
  logic [31:0] s_wdata_q, s_wdata_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;
  logic        timeout_q, timeout_d;
  logic        pick_m1;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  // last_q=1 means master 1 was served last, so master 0 wins a tie.
  assign pick_m1 = bus.m1_req & (~bus.m0_req | ~last_q);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    s_we_d     = s_we_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    timeout_d  = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          state_d   = STB;
          last_d    = pick_m1;
          grant_d   = pick_m1 ? 2'b10 : 2'b01;
          s_we_d    = pick_m1 ? bus.m1_we    : bus.m0_we;
          s_addr_d  = pick_m1 ? bus.m1_addr  : bus.m0_addr;
          s_wdata_d = pick_m1 ? bus.m1_wdata : bus.m0_wdata;
        end
      end
      STB: begin
        state_d = WAIT;
`ifdef BUS_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (bus.s_ready) begin
          state_d = DONE;
          if (grant_q[1]) m1_rdata_d = bus.s_rdata;
          else            m0_rdata_d = bus.s_rdata;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = DONE;
          cnt_d     = cnt_q + CW'(1);
          timeout_d = 1'b1;
          if (grant_q[1]) m1_rdata_d = 32'hFFFF_FFFF;
          else            m0_rdata_d = 32'hFFFF_FFFF;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      grant_q    <= 2'b00;
      last_q     <= 1'b1;
      s_we_q     <= 1'b0;
      s_addr_q   <= 32'h0;
      s_wdata_q  <= 32'h0;
      m0_rdata_q <= 32'h0;
      m1_rdata_q <= 32'h0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      s_we_q     <= s_we_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  always_ff @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
  assign o_timeout = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = timeout_q;
  assign o_timeout      = 1'b0;
`endif

  assign bus.s_stb    = (state_q == STB);
  assign bus.s_we     = s_we_q;
  assign bus.s_addr   = s_addr_q;
  assign bus.s_wdata  = s_wdata_q;
  assign bus.m0_rdata = m0_rdata_q;
  assign bus.m1_rdata = m1_rdata_q;
  assign bus.m0_ack   = (state_q == DONE) & grant_q[0];
  assign bus.m1_ack   = (state_q == DONE) & grant_q[1];
  assign o_grant      = grant_q;

endmodule

// File: tb/tb_bus_arbiter2.sv
// tb/tb_bus_arbiter2.sv - self-checking bench for bus_arbiter2 (transaction model + directed vectors).
module tb_bus_arbiter2;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  bus_arbiter2_if bus();
  logic [1:0] grant;
  logic       tmo;

  bus_arbiter2 #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_100mhz(clk),
    .rstn_i    (rstn),
    .bus       (bus),
    .o_grant   (grant),
    .o_timeout (tmo)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: busy/age describe where the current transfer is.
  bit          md_busy, md_done, md_tmo, md_last;
  int          md_age, md_owner, md_wcnt;
  logic        md_we;
  logic [31:0] md_addr, md_wdata;
  logic [31:0] md_rdata[2];

  // Observations of the DUT used by directed checks.
  logic [1:0]  stb_grant_q[$];
  int          stb_cyc_q[$];
  logic        stb_we_l;
  logic [31:0] stb_addr_l, stb_wdata_l;
  int          ack_cyc0[$], ack_cyc1[$];
  logic [1:0]  ack_grant_l;
  logic        ack_tmo_l;
  int          dual_ack = 0;

  task model_reset();
    md_busy = 0; md_done = 0; md_tmo = 0; md_last = 1;
    md_age = 0; md_owner = 0; md_wcnt = 0;
    md_we = 0; md_addr = 0; md_wdata = 0;
    md_rdata[0] = 0; md_rdata[1] = 0;
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      model_reset();
      chk("rst_grant", {30'h0, grant}, 32'h0);
      chk("rst_stb", {31'h0, bus.s_stb}, 32'h0);
      chk("rst_addr", bus.s_addr, 32'h0);
      chk("rst_acks", {30'h0, bus.m1_ack, bus.m0_ack}, 32'h0);
      chk("rst_rdata0", bus.m0_rdata, 32'h0);
      chk("rst_rdata1", bus.m1_rdata, 32'h0);
      chk("rst_tmo", {31'h0, tmo}, 32'h0);
    end else begin
      chk("s_stb", {31'h0, bus.s_stb}, {31'h0, md_busy && md_age == 1});
      chk("o_grant", {30'h0, grant}, md_busy ? (md_owner == 1 ? 32'h2 : 32'h1) : 32'h0);
      chk("m0_ack", {31'h0, bus.m0_ack}, {31'h0, md_busy && md_done && md_owner == 0});
      chk("m1_ack", {31'h0, bus.m1_ack}, {31'h0, md_busy && md_done && md_owner == 1});
      chk("o_timeout", {31'h0, tmo}, {31'h0, md_busy && md_done && md_tmo});
      chk("s_we", {31'h0, bus.s_we}, {31'h0, md_we});
      chk("s_addr", bus.s_addr, md_addr);
      chk("s_wdata", bus.s_wdata, md_wdata);
      chk("m0_rdata", bus.m0_rdata, md_rdata[0]);
      chk("m1_rdata", bus.m1_rdata, md_rdata[1]);

      if (bus.s_stb === 1'b1) begin
        stb_grant_q.push_back(grant);
        stb_cyc_q.push_back(cyc);
        stb_we_l = bus.s_we; stb_addr_l = bus.s_addr; stb_wdata_l = bus.s_wdata;
      end
      if (bus.m0_ack === 1'b1) begin ack_cyc0.push_back(cyc); ack_grant_l = grant; ack_tmo_l = tmo; end
      if (bus.m1_ack === 1'b1) begin ack_cyc1.push_back(cyc); ack_grant_l = grant; ack_tmo_l = tmo; end
      if (bus.m0_ack === 1'b1 && bus.m1_ack === 1'b1) dual_ack++;

      if (!md_busy) begin
        if (bus.m0_req || bus.m1_req) begin
          if (bus.m0_req && bus.m1_req) md_owner = md_last ? 0 : 1;
          else                          md_owner = bus.m1_req ? 1 : 0;
          md_last  = (md_owner == 1);
          md_we    = md_owner == 1 ? bus.m1_we    : bus.m0_we;
          md_addr  = md_owner == 1 ? bus.m1_addr  : bus.m0_addr;
          md_wdata = md_owner == 1 ? bus.m1_wdata : bus.m0_wdata;
          md_busy = 1; md_age = 1; md_done = 0; md_tmo = 0;
        end
      end else if (md_done) begin
        md_busy = 0;
      end else if (md_age == 1) begin
        md_age = 2; md_wcnt = 0;
      end else if (bus.s_ready) begin
        md_rdata[md_owner] = bus.s_rdata;
        md_done = 1;
      end else begin
`ifdef BUS_ARB_TIMEOUT_EN
        md_wcnt++;
        if (md_wcnt == TMO) begin
          md_rdata[md_owner] = 32'hFFFF_FFFF;
          md_done = 1; md_tmo = 1;
        end
`endif
      end
    end
  end

  // Reactive slave: s_ready in the slv_delay-th WAIT cycle (0 = never).
  int          slv_delay = 1;
  logic [31:0] slv_data = 32'h0;
  int          slv_cd = 0;
  bit          slv_armed = 0;
  initial begin
    bus.s_ready = 1'b0;
    bus.s_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      bus.s_rdata = slv_data;
      if (!rstn) begin
        slv_armed = 0; bus.s_ready = 1'b0;
      end else if (bus.s_stb === 1'b1) begin
        slv_armed = (slv_delay > 0); slv_cd = slv_delay; bus.s_ready = 1'b0;
      end else if (slv_armed) begin
        slv_cd--;
        if (slv_cd == 0) begin bus.s_ready = 1'b1; slv_armed = 0; end
      end else begin
        bus.s_ready = 1'b0;
      end
    end
  end

  task automatic drive(input int m, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (m == 0) begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
    end else begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
    end
  endtask

  task automatic run_master(input int m, input int n, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata);
    int got = 0;
    int waited = 0;
    logic [31:0] a = addr;
    drive(m, 1'b1, we, a, wdata);
    while (got < n && waited < 200) begin
      @(negedge clk); waited++;
      if ((m == 0 && bus.m0_ack === 1'b1) || (m == 1 && bus.m1_ack === 1'b1)) begin
        got++;
        @(posedge clk); #1;
        a = a + 32'h4;
        drive(m, got < n, we, a, wdata);
      end
    end
    chk($sformatf("m%0d_ack_count", m), got, n);
    if (got < n) drive(m, 1'b0, we, a, wdata);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int t0, n0, a0, a1, s0;
  initial begin
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    model_reset();
    rstn = 1'b0;
    idle(3);
    rstn = 1'b1;
    idle(2);

    // Master 0 read, ready in second WAIT cycle.
    slv_delay = 2; slv_data = 32'h0000_0055;
    t0 = cyc;
    run_master(0, 1, 1'b0, 32'h0000_1234, 32'hDEAD_0000);
    chk("t1_latency", ack_cyc0[$] - t0, 4);
    chk("t1_rdata0", bus.m0_rdata, 32'h0000_0055);
    chk("t1_rdata1", bus.m1_rdata, 32'h0);
    chk("t1_stb_addr", stb_addr_l, 32'h0000_1234);
    chk("t1_stb_we", {31'h0, stb_we_l}, 32'h0);
    idle(2);

    // Master 1 write, ready immediately.
    slv_delay = 1; slv_data = 32'hCAFE_0001;
    t0 = cyc;
    run_master(1, 1, 1'b1, 32'h4000_0010, 32'h0000_BEEF);
    chk("t2_latency", ack_cyc1[$] - t0, 3);
    chk("t2_stb_we", {31'h0, stb_we_l}, 32'h1);
    chk("t2_stb_addr", stb_addr_l, 32'h4000_0010);
    chk("t2_stb_wdata", stb_wdata_l, 32'h0000_BEEF);
    chk("t2_stb_grant", {30'h0, stb_grant_q[$]}, 32'h2);
    chk("t2_ack_grant", {30'h0, ack_grant_l}, 32'h2);
    chk("t2_rdata0_kept", bus.m0_rdata, 32'h0000_0055);

    // Sustained dual requests straight out of reset.
    rstn = 1'b0;
    idle(2);
    rstn = 1'b1;
    n0 = stb_grant_q.size();
    fork
      run_master(0, 3, 1'b0, 32'h0000_0100, 32'h0);
      run_master(1, 3, 1'b1, 32'h0000_0200, 32'h0000_0077);
    join
    chk("t3_stb_count", stb_grant_q.size() - n0, 6);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_grant%0d", i), {30'h0, stb_grant_q[n0 + i]}, (i % 2 == 0) ? 32'h1 : 32'h2);
      chk($sformatf("t3_period%0d", i), stb_cyc_q[n0 + i + 1] - stb_cyc_q[n0 + i], 4);
    end
    chk("t3_dual_ack", dual_ack, 0);
    idle(2);

    // Slave never answers.
    slv_delay = 0;
    a0 = ack_cyc0.size();
    t0 = cyc;
    drive(0, 1'b1, 1'b0, 32'h0000_0008, 32'h0);
`ifdef BUS_ARB_TIMEOUT_EN
    for (int i = 0; i < 100 && ack_cyc0.size() == a0; i++) @(negedge clk);
    chk("t4_ack_seen", ack_cyc0.size() - a0, 1);
    if (ack_cyc0.size() > a0) begin
      chk("t4_latency", ack_cyc0[$] - t0, 2 + TMO);
      chk("t4_tmo_with_ack", {31'h0, ack_tmo_l}, 32'h1);
      chk("t4_rdata0", bus.m0_rdata, 32'hFFFF_FFFF);
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0000_0008, 32'h0);
`else
    repeat (1000) @(negedge clk);
    chk("t4_still_granted", {30'h0, grant}, 32'h1);
    chk("t4_no_ack", ack_cyc0.size() - a0, 0);
    chk("t4_tmo_low", {31'h0, tmo}, 32'h0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    rstn = 1'b0;
    idle(2);
    rstn = 1'b1;
`endif
    idle(2);

    // Reset during WAIT of a master 1 transfer.
    slv_delay = 0;
    a1 = ack_cyc1.size();
    drive(1, 1'b1, 1'b0, 32'h0000_0300, 32'h0);
    idle(5);
    #2 rstn = 1'b0;
    #1;
    chk("t5_async_grant", {30'h0, grant}, 32'h0);
    chk("t5_async_addr", bus.s_addr, 32'h0);
    chk("t5_async_rdata0", bus.m0_rdata, 32'h0);
    chk("t5_async_ack1", {31'h0, bus.m1_ack}, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(2);
    rstn = 1'b1;
    slv_delay = 1;
    n0 = stb_grant_q.size();
    fork
      run_master(0, 1, 1'b0, 32'h0000_0010, 32'h0);
      run_master(1, 1, 1'b0, 32'h0000_0020, 32'h0);
    join
    chk("t5_no_abandoned_ack", ack_cyc1.size() - a1, 1);
    chk("t5_first_grant", {30'h0, stb_grant_q[n0]}, 32'h1);
    idle(2);

    // m0_req dropped mid-transaction.
    slv_delay = 3; slv_data = 32'h0000_0ABC;
    a0 = ack_cyc0.size();
    s0 = stb_grant_q.size();
    t0 = cyc;
    drive(0, 1'b1, 1'b0, 32'h0000_0044, 32'h0);
    idle(2);
    drive(0, 1'b0, 1'b0, 32'h0000_0044, 32'h0);
    for (int i = 0; i < 20 && ack_cyc0.size() == a0; i++) @(negedge clk);
    chk("t6_ack_seen", ack_cyc0.size() - a0, 1);
    if (ack_cyc0.size() > a0) chk("t6_latency", ack_cyc0[$] - t0, 5);
    idle(10);
    chk("t6_single_stb", stb_grant_q.size() - s0, 1);
    chk("t6_rdata0", bus.m0_rdata, 32'h0000_0ABC);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
